// File: rtl/sap1_prog_loader.sv
// +----------------------------------------------------------------------+
// | sap1_prog_loader: streams host bytes into SAP-1 RAM via the program   |
// | port, holding the CPU in reset while loading.          Rev 1.0        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sap1_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              abort,
  output logic              pr_mode,
  output logic [ADDR_W-1:0] pr_address,
  output logic [DATA_W-1:0] pr_data,
  output logic              pr_write,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_REL1   = 3'd5,
    S_REL2   = 3'd6
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN     = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] CNT_ONE     = (ADDR_W+1)'(1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE-1);

  state_t          state, state_nxt;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] cnt;
  logic [3:0]      settle_cnt;
  logic            bad_done;
  logic            len_ok;
  logic            start_ok;
  logic            start_bad;
  logic            accept;
  logic            last_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    accept    = 1'b0;
    len_ok    = (length != '0) && (length <= MAX_LEN);
    last_word = ((cnt + CNT_ONE) == len_q);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            start_ok  = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_nxt = S_REL1;
        end else if (byte_valid) begin
          accept    = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort)                           state_nxt = S_REL1;
        else if (settle_cnt == SETTLE_LAST)  state_nxt = S_STROBE;
      end
      // The strobe cycle itself is the whole write, so an abort here never cuts a write short.
      S_STROBE: state_nxt = abort ? S_REL1 : S_HOLD;
      S_HOLD:   state_nxt = (abort || last_word) ? S_REL1 : S_WAIT;
      S_REL1:   state_nxt = S_REL2;
      S_REL2:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign pr_mode    = (state == S_WAIT) || (state == S_SETUP) ||
                      (state == S_STROBE) || (state == S_HOLD);
  assign cpu_hold   = pr_mode || (state == S_REL1);
  assign byte_ready = (state == S_WAIT);
  assign pr_write   = (state == S_STROBE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_REL2) || bad_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      pr_address <= '0;
      pr_data    <= '0;
      error      <= 1'b0;
      bad_done   <= 1'b0;
    end else begin
      bad_done <= start_bad;
      if (start_ok) begin
        len_q <= length;
        cnt   <= '0;
        error <= 1'b0;
      end
      if (start_bad || (abort && pr_mode)) error <= 1'b1;
      if (accept) begin
        pr_data    <= byte_in;
        pr_address <= cnt[ADDR_W-1:0];
        settle_cnt <= '0;
      end else if (state == S_SETUP) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
      if (state == S_HOLD) cnt <= cnt + CNT_ONE;
      // Address/data return to zero together with the done pulse.
      if (state == S_REL1) begin
        pr_address <= '0;
        pr_data    <= '0;
      end
    end
  end

endmodule

`default_nettype wire
